// File: rtl/epd_fsm.sv
// Ethernet-style frame parser: checks preamble/SFD, walks the destination,
// source and type/length fields, sizes the payload and counts the frames
// that were valid end to end.
module epd_fsm #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              control,
  output logic              preamble_valid,
  output logic              dst_addr_valid,
  output logic              src_addr_valid,
  output logic              type_length_valid,
  output logic              packet_size_valid,
  output logic [3:0]        valid_packet_counter
);

  localparam logic [DATA_W-1:0] PRE_BYTE    = DATA_W'(8'h55);
  localparam logic [DATA_W-1:0] SFD_BYTE    = DATA_W'(8'hD5);
  localparam logic [2:0]        PRE_MIN     = 3'd7;
  localparam logic [2:0]        ADDR_LAST   = 3'd5;
  localparam logic [15:0]       TL_MAX_LEN  = 16'h05DC;
  localparam logic [15:0]       TL_MIN_TYPE = 16'h0600;
  localparam logic [10:0]       PAY_MIN     = 11'd46;
  localparam logic [10:0]       PAY_MAX     = 11'd1500;

  typedef enum logic [2:0] {
    IDLE,
    DST,
    SRC,
    TYPE,
    PAYLOAD,
    DONE,
    DROP
  } state_t;

  state_t          state;
  logic [2:0]      pre_cnt;
  logic [2:0]      byte_cnt;
  logic [10:0]     pay_cnt;
  logic [DATA_W-1:0] type_msb;
  logic [4:0]      flags;
  logic [3:0]      frame_cnt;

  // Lengths up to 1500 and EtherTypes from 0x0600 are meaningful; the gap
  // between them is reserved and the frame is discarded.
  function automatic logic type_ok(input logic [15:0] v);
    return (v <= TL_MAX_LEN) || (v >= TL_MIN_TYPE);
  endfunction

  function automatic logic size_ok(input logic [10:0] n);
    return (n >= PAY_MIN) && (n <= PAY_MAX);
  endfunction

  // Preamble run length only needs to know "at least seven", so it sticks at 7.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // Payload counter sticks at 2047 so oversize frames never wrap into range.
  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  assign preamble_valid       = flags[0];
  assign dst_addr_valid       = flags[1];
  assign src_addr_valid       = flags[2];
  assign type_length_valid    = flags[3];
  assign packet_size_valid    = flags[4];
  assign valid_packet_counter = frame_cnt;

  // Frame state machine; every output bit is a flop updated here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pre_cnt   <= 3'd0;
      byte_cnt  <= 3'd0;
      pay_cnt   <= 11'd0;
      flags     <= 5'd0;
      frame_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!control) begin
            pre_cnt <= 3'd0;
          end else if (data == PRE_BYTE) begin
            pre_cnt <= sat_inc3(pre_cnt);
          end else if ((data == SFD_BYTE) && (pre_cnt >= PRE_MIN)) begin
            state    <= DST;
            flags[0] <= 1'b1;
            pre_cnt  <= 3'd0;
            byte_cnt <= 3'd0;
          end else begin
            pre_cnt <= 3'd0;
          end
        end

        DST: begin
          if (!control) begin
            state    <= IDLE;
            flags    <= 5'd0;
            byte_cnt <= 3'd0;
          end else if (byte_cnt == ADDR_LAST) begin
            state    <= SRC;
            flags[1] <= 1'b1;
            byte_cnt <= 3'd0;
          end else begin
            byte_cnt <= byte_cnt + 3'd1;
          end
        end

        SRC: begin
          if (!control) begin
            state    <= IDLE;
            flags    <= 5'd0;
            byte_cnt <= 3'd0;
          end else if (byte_cnt == ADDR_LAST) begin
            state    <= TYPE;
            flags[2] <= 1'b1;
            byte_cnt <= 3'd0;
          end else begin
            byte_cnt <= byte_cnt + 3'd1;
          end
        end

        TYPE: begin
          if (!control) begin
            state    <= IDLE;
            flags    <= 5'd0;
            byte_cnt <= 3'd0;
          end else if (byte_cnt == 3'd0) begin
            byte_cnt <= 3'd1;
          end else if (type_ok({type_msb, data})) begin
            state    <= PAYLOAD;
            flags[3] <= 1'b1;
            pay_cnt  <= 11'd0;
            byte_cnt <= 3'd0;
          end else begin
            state    <= DROP;
            byte_cnt <= 3'd0;
          end
        end

        PAYLOAD: begin
          if (!control) begin
            state    <= DONE;
            flags[4] <= size_ok(pay_cnt);
          end else begin
            pay_cnt <= sat_inc11(pay_cnt);
          end
        end

        DONE: begin
          if (&flags) begin
            frame_cnt <= frame_cnt + 4'd1;
          end
          state    <= IDLE;
          flags    <= 5'd0;
          pre_cnt  <= 3'd0;
          byte_cnt <= 3'd0;
          pay_cnt  <= 11'd0;
        end

        DROP: begin
          if (!control) begin
            state    <= IDLE;
            flags    <= 5'd0;
            byte_cnt <= 3'd0;
          end
        end

        default: begin
          state    <= IDLE;
          flags    <= 5'd0;
          pre_cnt  <= 3'd0;
          byte_cnt <= 3'd0;
          pay_cnt  <= 11'd0;
        end
      endcase
    end
  end

  // Hold the high type byte until the low byte arrives; pure data, no reset.
  always_ff @(posedge clock) begin
    if ((state == TYPE) && control && (byte_cnt == 3'd0)) begin
      type_msb <= data;
    end
  end

endmodule

// File: tb/tb_epd_fsm.sv
// Bench for epd_fsm: directed frames, a field-offset reference model checked
// every cycle, and literal expectations at key points of each scenario.
module tb_epd_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data = 8'd0;
  logic       control = 1'b0;
  logic       preamble_valid;
  logic       dst_addr_valid;
  logic       src_addr_valid;
  logic       type_length_valid;
  logic       packet_size_valid;
  logic [3:0] valid_packet_counter;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  epd_fsm dut (
    .clock                (clock),
    .reset                (reset),
    .data                 (data),
    .control              (control),
    .preamble_valid       (preamble_valid),
    .dst_addr_valid       (dst_addr_valid),
    .src_addr_valid       (src_addr_valid),
    .type_length_valid    (type_length_valid),
    .packet_size_valid    (packet_size_valid),
    .valid_packet_counter (valid_packet_counter)
  );

  always #5 clock = ~clock;

  // Reference model: position of the byte within the frame after the SFD.
  int          m_run = 0;
  int          m_pos = 0;
  bit          m_in = 1'b0;
  bit          m_done = 1'b0;
  bit          m_psv = 1'b0;
  logic [15:0] m_tl = 16'd0;
  logic [3:0]  m_cnt = 4'd0;

  function automatic bit legal_tl(input logic [15:0] v);
    return (v <= 16'h05DC) || (v >= 16'h0600);
  endfunction

  // Expected flags as {size, type, src, dst, preamble}.
  function automatic logic [4:0] exp_flags();
    logic [4:0] f;
    f[0] = m_in;
    f[1] = m_in && (m_pos >= 6);
    f[2] = m_in && (m_pos >= 12);
    f[3] = m_in && (m_pos >= 14) && legal_tl(m_tl);
    f[4] = m_psv;
    return f;
  endfunction

  // Advance the model on each clock; reset clears it immediately.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_run = 0; m_pos = 0; m_in = 1'b0; m_done = 1'b0; m_psv = 1'b0; m_cnt = 4'd0;
    end else if (m_done) begin
      if (&exp_flags()) m_cnt = m_cnt + 4'd1;
      m_done = 1'b0; m_psv = 1'b0; m_in = 1'b0; m_pos = 0; m_run = 0;
    end else if (!m_in) begin
      if (control && data == 8'h55) m_run = m_run + 1;
      else if (control && data == 8'hD5 && m_run >= 7) begin
        m_in = 1'b1; m_pos = 0; m_run = 0;
      end else m_run = 0;
    end else if (!control) begin
      if (m_pos >= 14 && legal_tl(m_tl)) begin
        m_done = 1'b1;
        m_psv  = ((m_pos - 14) >= 46) && ((m_pos - 14) <= 1500);
      end else begin
        m_in = 1'b0; m_pos = 0;
      end
    end else begin
      if (m_pos == 12) m_tl[15:8] = data;
      if (m_pos == 13) m_tl[7:0] = data;
      m_pos = m_pos + 1;
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      tests++;
      if ({packet_size_valid, type_length_valid, src_addr_valid, dst_addr_valid,
           preamble_valid, valid_packet_counter} !== {exp_flags(), m_cnt}) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t dut flags=%b cnt=%0d model flags=%b cnt=%0d", $time,
                 {packet_size_valid, type_length_valid, src_addr_valid, dst_addr_valid,
                  preamble_valid}, valid_packet_counter, exp_flags(), m_cnt);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic [7:0] d);
    control = c;
    data    = d;
    @(posedge clock);
    #1;
  endtask

  task automatic pre(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 8'h55);
    cyc(1'b1, 8'hD5);
  endtask

  task automatic dst_bytes();
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(i + 1));
  endtask

  task automatic src_bytes();
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(255 - i));
  endtask

  task automatic pay(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 8'(i));
  endtask

  task automatic send_frame(input int n55, input logic [7:0] th, input logic [7:0] tl,
                            input int npay, output logic psv_seen);
    pre(n55);
    dst_bytes();
    src_bytes();
    cyc(1'b1, th);
    cyc(1'b1, tl);
    pay(npay);
    cyc(1'b0, 8'd0);
    psv_seen = packet_size_valid;
    cyc(1'b0, 8'd0);
  endtask

  task automatic pulse_reset();
    control = 1'b0;
    data    = 8'd0;
    reset   = 1'b1;
    #1;
    chk("rst_flags", 16'({packet_size_valid, type_length_valid, src_addr_valid,
                          dst_addr_valid, preamble_valid}), 16'd0);
    chk("rst_cnt", 16'(valid_packet_counter), 16'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc(1'b0, 8'd0);
  endtask

  logic psv;

  initial begin
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    cmp_en = 1'b1;
    chk("reset_flags", 16'({packet_size_valid, type_length_valid, src_addr_valid,
                            dst_addr_valid, preamble_valid}), 16'd0);
    chk("reset_cnt", 16'(valid_packet_counter), 16'd0);
    reset = 1'b0;
    cyc(1'b0, 8'd0);

    // Nominal frame, 50 payload bytes; flags rise field by field.
    pre(7);
    chk("f1_pre", 16'(preamble_valid), 16'd1);
    chk("f1_dst_early", 16'(dst_addr_valid), 16'd0);
    dst_bytes();
    chk("f1_dst", 16'(dst_addr_valid), 16'd1);
    chk("f1_src_early", 16'(src_addr_valid), 16'd0);
    src_bytes();
    chk("f1_src", 16'(src_addr_valid), 16'd1);
    chk("f1_tl_early", 16'(type_length_valid), 16'd0);
    cyc(1'b1, 8'h08);
    cyc(1'b1, 8'h00);
    chk("f1_tl", 16'(type_length_valid), 16'd1);
    pay(50);
    chk("f1_psv_early", 16'(packet_size_valid), 16'd0);
    cyc(1'b0, 8'd0);
    chk("f1_psv_done", 16'(packet_size_valid), 16'd1);
    chk("f1_cnt_done", 16'(valid_packet_counter), 16'd0);
    cyc(1'b0, 8'd0);
    chk("f1_flags_after", 16'({packet_size_valid, type_length_valid, src_addr_valid,
                               dst_addr_valid, preamble_valid}), 16'd0);
    chk("f1_cnt", 16'(valid_packet_counter), 16'd1);

    // Short payload.
    send_frame(7, 8'h08, 8'h00, 40, psv);
    chk("f40_psv", 16'(psv), 16'd0);
    chk("f40_cnt", 16'(valid_packet_counter), 16'd1);

    // Short preamble rejected, then a good one accepted immediately.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h55);
    cyc(1'b1, 8'hD5);
    chk("short_pre", 16'(preamble_valid), 16'd0);
    send_frame(7, 8'h08, 8'h00, 46, psv);
    chk("after_short_pre_cnt", 16'(valid_packet_counter), 16'd2);

    // Reserved type value -> drop until control falls.
    pre(7);
    dst_bytes();
    src_bytes();
    cyc(1'b1, 8'h05);
    cyc(1'b1, 8'hE0);
    chk("drop_tl", 16'(type_length_valid), 16'd0);
    pay(10);
    chk("drop_pre_held", 16'(preamble_valid), 16'd1);
    cyc(1'b0, 8'd0);
    chk("drop_end_pre", 16'(preamble_valid), 16'd0);
    cyc(1'b0, 8'd0);
    chk("drop_cnt", 16'(valid_packet_counter), 16'd2);

    // Payload size and type/length boundaries.
    send_frame(7, 8'h08, 8'h00, 45, psv);
    chk("pay45", 16'(psv), 16'd0);
    send_frame(7, 8'h08, 8'h00, 1500, psv);
    chk("pay1500", 16'(psv), 16'd1);
    chk("pay1500_cnt", 16'(valid_packet_counter), 16'd3);
    send_frame(7, 8'h08, 8'h00, 1501, psv);
    chk("pay1501", 16'(psv), 16'd0);
    send_frame(7, 8'h05, 8'hDC, 46, psv);
    chk("tl05dc_cnt", 16'(valid_packet_counter), 16'd4);
    send_frame(7, 8'h06, 8'h00, 46, psv);
    chk("tl0600_cnt", 16'(valid_packet_counter), 16'd5);
    send_frame(7, 8'h05, 8'hDD, 46, psv);
    chk("tl05dd_psv", 16'(psv), 16'd0);
    send_frame(7, 8'h05, 8'hFF, 46, psv);
    chk("tl05ff_cnt", 16'(valid_packet_counter), 16'd5);
    send_frame(7, 8'h08, 8'h00, 2100, psv);
    chk("pay2100", 16'(psv), 16'd0);

    // Abort inside the destination field.
    pre(7);
    cyc(1'b1, 8'h01);
    cyc(1'b1, 8'h02);
    cyc(1'b0, 8'd0);
    chk("abort_dst_pre", 16'(preamble_valid), 16'd0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'h55);
    cyc(1'b1, 8'hD5);
    chk("six_pre", 16'(preamble_valid), 16'd0);
    cyc(1'b0, 8'd0);
    send_frame(8, 8'h08, 8'h00, 46, psv);
    chk("eight_pre_cnt", 16'(valid_packet_counter), 16'd6);

    // Sixteen good frames from reset: counter reaches 15 then wraps.
    pulse_reset();
    for (int n = 1; n <= 16; n++) begin
      send_frame(7, 8'h08, 8'h00, 46, psv);
      if (n == 15) chk("cnt15", 16'(valid_packet_counter), 16'd15);
    end
    chk("cnt_wrap", 16'(valid_packet_counter), 16'd0);

    // Reset inside the source field discards the frame.
    send_frame(7, 8'h08, 8'h00, 46, psv);
    chk("pre_rst_cnt", 16'(valid_packet_counter), 16'd1);
    pre(7);
    dst_bytes();
    cyc(1'b1, 8'hFF);
    cyc(1'b1, 8'hFE);
    cyc(1'b1, 8'hFD);
    pulse_reset();
    cyc(1'b1, 8'hFC);
    cyc(1'b1, 8'hFB);
    cyc(1'b1, 8'hFA);
    cyc(1'b1, 8'h08);
    cyc(1'b1, 8'h00);
    chk("post_rst_idle", 16'(preamble_valid), 16'd0);
    cyc(1'b0, 8'd0);
    send_frame(7, 8'h08, 8'h00, 50, psv);
    chk("post_rst_cnt", 16'(valid_packet_counter), 16'd1);

    cyc(1'b0, 8'd0);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/epd_fsm.md
EPD_FSM -- requirements
Module: epd_fsm

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port data, input, 8 bits: received frame byte, sampled on rising clock when control=1.
REQ-004 SHALL have port control, input, 1 bit: 1 = data carries a valid frame byte; a 1->0 transition ends the frame.
REQ-005 SHALL have port preamble_valid, output, 1 bit: preamble + SFD (start-of-frame delimiter) accepted.
REQ-006 SHALL have port dst_addr_valid, output, 1 bit: 6-byte destination address received.
REQ-007 SHALL have port src_addr_valid, output, 1 bit: 6-byte source address received.
REQ-008 SHALL have port type_length_valid, output, 1 bit: 2-byte type/length field received and legal.
REQ-009 SHALL have port packet_size_valid, output, 1 bit: payload byte count legal at frame end.
REQ-010 SHALL have port valid_packet_counter, output, 4 bits: count of fully valid frames.
REQ-011 SHALL have port order: clock, reset, data, control, preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid, packet_size_valid, valid_packet_counter.

Function
REQ-012 SHALL implement states IDLE, DST, SRC, TYPE, PAYLOAD, DONE, DROP; every byte is consumed only when control=1.
REQ-013 IDLE SHALL count consecutive 0x55 bytes; the count saturates at 7.
REQ-014 In IDLE, any byte other than 0x55 or 0xD5 SHALL clear the count.
REQ-015 In IDLE, 0xD5 with count>=7 SHALL move to DST and set preamble_valid on the next clock.
REQ-016 In IDLE, 0xD5 with count<7 SHALL clear the count and remain in IDLE.
REQ-017 DST SHALL consume exactly 6 bytes, then set dst_addr_valid and move to SRC.
REQ-018 SRC SHALL consume exactly 6 bytes, then set src_addr_valid and move to TYPE.
REQ-019 TYPE SHALL capture 2 bytes MSB first; value <=0x05DC or >=0x0600 SHALL set type_length_valid and move to PAYLOAD.
REQ-020 TYPE value in 0x05DD-0x05FF SHALL move to DROP.
REQ-021 Each valid flag SHALL rise one clock after the last byte of its field is sampled and hold until the state machine returns to IDLE.
REQ-022 PAYLOAD SHALL count bytes in an 11-bit counter that saturates at 2047.
REQ-023 In PAYLOAD, control=0 SHALL move to DONE.
REQ-024 DONE SHALL last exactly one cycle and SHALL assert packet_size_valid iff 46 <= payload count <= 1500.
REQ-025 In DONE, valid_packet_counter SHALL increment by 1, wrapping 15->0, iff all five flags are 1.
REQ-026 DONE SHALL always go to IDLE next cycle, clearing all flags and byte/payload counts.
REQ-027 control=0 in DST, SRC or TYPE SHALL abort the frame: go to IDLE, clear flags, no counter increment.
REQ-028 DROP SHALL ignore data until control=0, then go to IDLE with flags cleared and no increment.
REQ-029 control=0 in IDLE SHALL clear the preamble count.
REQ-030 All outputs SHALL be registered.
REQ-031 valid_packet_counter SHALL change only in DONE or on reset.

Reset
REQ-032 reset=1 SHALL immediately force IDLE and clear all flags, the preamble count, field/payload counters and valid_packet_counter (all outputs 0).
REQ-033 Reset asserted mid-frame SHALL discard the frame; after reset deasserts, the next frame must start with a fresh preamble.

Verification
REQ-034 Sequence 7x55,D5; DST 01..06; SRC FF..FA; type 08 00; 50 payload bytes; then control=0 -> flags rise in order, packet_size_valid=1 in DONE, counter 0->1, flags 0 after DONE.
REQ-035 Same frame with 40 payload bytes -> packet_size_valid=0, counter unchanged.
REQ-036 Preamble 5x55,D5 -> stays IDLE, preamble_valid=0; then a correct preamble is accepted.
REQ-037 Type bytes 05 E0 -> type_length_valid=0, DROP until control=0, no increment.
REQ-038 16 valid frames from reset -> counter reaches 15, then wraps to 0.
REQ-039 reset pulse during SRC -> all outputs 0 at once; the next full frame counts as 1.
